ex_entity_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one ExEntity datapath (OUT = A + B - DELTA)

---
 rtl/ex_entity_arbiter_if.sv | 38 +++
 rtl/ex_entity_arbiter.sv | 151 +++++++++++++++
 tb/tb_ex_entity_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_entity_arbiter_if.sv
// Request/result channel bundle between client units and ex_entity_arbiter.
// Per-requester operands are packed at [i*NBITS +: NBITS].
interface ex_entity_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*NBITS-1:0] req_a;
    logic [NREQ*NBITS-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [NBITS-1:0]      res_data;
    logic [IDW-1:0]        res_id;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output res_ready,
        input  req_ready,
        input  res_valid,
        input  res_data,
        input  res_id
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  res_ready,
        output req_ready,
        output res_valid,
        output res_data,
        output res_id
    );
endinterface

// File: rtl/ex_entity_arbiter.sv
// Round-robin arbiter sharing one ExEntity datapath (A + B - DELTA) among NREQ clients.
// One request in flight at a time: IDLE grant -> EXEC -> DONE handoff.
module ex_entity #(
    parameter int NBITS = 8,
    parameter int DELTA = 16
) (
    input  logic [NBITS-1:0] in_a_i,
    input  logic [NBITS-1:0] in_b_i,
    output logic [NBITS-1:0] out_data_o
);
    // Wraps modulo 2^NBITS; no carry or borrow is reported.
    assign out_data_o = in_a_i + in_b_i - NBITS'(DELTA);
endmodule

module ex_entity_arbiter #(
    parameter  int NBITS = 8,
    parameter  int DELTA = 16,
    parameter  int NREQ  = 4,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ex_entity_arbiter_if.slave  bus,
    output logic                busy_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NBITS-1:0] op_a_q, op_a_d;
    logic [NBITS-1:0] op_b_q, op_b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [NBITS-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             res_valid_q, res_valid_d;

    logic             found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     scan_idx;
    logic [IDW:0]     next_ptr;
    logic [NBITS-1:0] ex_out;

    // First valid requester at or after the pointer, wrapping mod NREQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!found && bus.req_valid[scan_idx[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        next_ptr = {1'b0, grant_idx} + (IDW+1)'(1);
        if (next_ptr >= (IDW+1)'(NREQ)) begin
            next_ptr = '0;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && found && !rst_i) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    ex_entity #(
        .NBITS (NBITS),
        .DELTA (DELTA)
    ) u_ex_entity (
        .in_a_i     (op_a_q),
        .in_b_i     (op_b_q),
        .out_data_o (ex_out)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_a_d  = bus.req_a[grant_idx*NBITS +: NBITS];
                    op_b_d  = bus.req_b[grant_idx*NBITS +: NBITS];
                    id_d    = grant_idx;
                    ptr_d   = next_ptr[IDW-1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = ex_out;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Handoff cycle never grants; the next grant waits for IDLE.
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_ex_entity_arbiter.sv
// Directed bench for ex_entity_arbiter with NBITS=8, DELTA=7, NREQ=4.
module tb_ex_entity_arbiter;
    localparam int NBITS = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic clk;
    logic rst;
    logic busy;
    int   n_cmp;
    int   n_fail;

    ex_entity_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS), .IDW(IDW)) bus ();

    ex_entity_arbiter #(
        .NBITS (NBITS),
        .DELTA (7),
        .NREQ  (NREQ)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*NBITS +: NBITS] = a;
        bus.req_b[i*NBITS +: NBITS] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_res_valid got %b want 0", bus.res_valid);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy got %b want 0", busy);
        end
        n_cmp++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rst_req_ready got %b want 0000", bus.req_ready);
        end
        n_cmp++;
        if (bus.res_data !== 8'h00 || bus.res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_res got %h/%0d want 00/0", bus.res_data, bus.res_id);
        end
        bus.req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_op(2, 8'd10, 8'd20);
        bus.req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready got %b want 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        n_cmp++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b1 || bus.req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL single_exec got v=%b busy=%b rdy=%b want 0/1/0000",
                     bus.res_valid, busy, bus.req_ready);
        end
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'd23 || bus.res_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_res got v=%b d=%0d id=%0d want 1/23/2",
                     bus.res_valid, bus.res_data, bus.res_id);
        end
        bus.res_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_handoff got v=%b busy=%b want 0/0", bus.res_valid, busy);
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] a_t [2];
        logic [7:0] b_t [2];
        logic [7:0] e_t [2];
        a_t = '{8'd2, 8'd255};
        b_t = '{8'd3, 8'd255};
        e_t = '{8'hFE, 8'hF7};
        bus.res_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            set_op(0, a_t[j], b_t[j]);
            bus.req_valid = 4'b0001;
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'b0001) begin
                n_fail++; $display("FAIL wrap_ready[%0d] got %b want 0001", j, bus.req_ready);
            end
            tick();
            bus.req_valid = '0;
            tick();
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== e_t[j] || bus.res_id !== 2'd0) begin
                n_fail++;
                $display("FAIL wrap_res[%0d] got v=%b d=%h id=%0d want 1/%h/0",
                         j, bus.res_valid, bus.res_data, bus.res_id, e_t[j]);
            end
            tick();
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_fairness();
        logic [7:0] exp_d [4];
        int         ids [8];
        exp_d = '{8'hF9, 8'd4, 8'd15, 8'd26};
        ids   = '{0, 1, 2, 3, 0, 1, 3, 1};
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_op(i, 8'(i * 10), 8'(i));
        end
        bus.res_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            bus.req_valid = (j < 5) ? 4'b1111 : 4'b1010;
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'(1 << ids[j])) begin
                n_fail++;
                $display("FAIL fair_ready[%0d] got %b want id %0d", j, bus.req_ready, ids[j]);
            end
            tick();
            n_cmp++;
            if (bus.res_valid !== 1'b0) begin
                n_fail++; $display("FAIL fair_early[%0d] got v=%b want 0", j, bus.res_valid);
            end
            tick();
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(ids[j]) ||
                bus.res_data !== exp_d[ids[j]]) begin
                n_fail++;
                $display("FAIL fair_res[%0d] got v=%b id=%0d d=%h want 1/%0d/%h",
                         j, bus.res_valid, bus.res_id, bus.res_data, ids[j], exp_d[ids[j]]);
            end
            tick();
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0011;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_ready got %b want 0001", bus.req_ready);
        end
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 8'hF9 ||
                bus.res_id !== 2'd0 || bus.req_ready !== 4'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d rdy=%b want 1/f9/0/0000",
                         c, bus.res_valid, bus.res_data, bus.res_id, bus.req_ready);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_next got v=%b rdy=%b want 0/0010", bus.res_valid, bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_data !== 8'd4) begin
            n_fail++;
            $display("FAIL bp_res got v=%b id=%0d d=%h want 1/1/04",
                     bus.res_valid, bus.res_id, bus.res_data);
        end
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        bus.req_valid = 4'b0001;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL midop_busy got %b want 1", busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL midop_rst got v=%b busy=%b rdy=%b want 0/0/0000",
                     bus.res_valid, busy, bus.req_ready);
        end
        tick();
        rst = 1'b0;
        set_op(3, 8'd1, 8'd6);
        bus.req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL midop_ready got %b want 1000", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        tick();
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h00 || bus.res_id !== 2'd3) begin
            n_fail++;
            $display("FAIL midop_res got v=%b d=%h id=%0d want 1/00/3",
                     bus.res_valid, bus.res_data, bus.res_id);
        end
        bus.res_ready = 1'b1;
        tick();
    endtask

    task automatic test_withdrawn();
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL wd_res got v=%b id=%0d want 1/0", bus.res_valid, bus.res_id);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0) begin
                n_fail++;
                $display("FAIL wd_idle[%0d] got v=%b busy=%b rdy=%b want 0/0/0000",
                         c, bus.res_valid, busy, bus.req_ready);
            end
        end
        bus.res_ready = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        test_withdrawn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
